emu_io_bridge: RTL
==================

// Module: emu_io_bridge
// PURPOSE
//  Parametrised byte-stream bridge between the host-side emulator and the board I/O vector of a DUT.
//  Host writes the input vector (SW/KEY) and reads output snapshots (LED/HEX) over valid/ready
//  byte channels. Optional auto-report mode pushes a snapshot whenever outputs change.
//  Sits between the host link (UART/JTAG byte FIFO) and the DUT wrapper; replaces direct state poking.
// PARAMETERS
//  IN_W      14  input vector width driven to DUT (SW[9:0], KEY[13:10])
//  OUT_W     52  output vector width sampled from DUT (LED, HEX0..HEX5)
//  IN_BYTES  derived = ceil(IN_W/8); localparam, not overridable
//  OUT_BYTES derived = ceil(OUT_W/8); localparam, not overridable
// PORTS
//  CLK            in   1        system clock
//  RST_N          in   1        synchronous reset, active-low
//  RX_DATA        in   8        host command/payload byte
//  RX_VALID       in   1        RX_DATA valid
//  RX_READY       out  1        bridge accepts byte; handshake = RX_VALID & RX_READY
//  TX_DATA        out  8        response byte to host
//  TX_VALID       out  1        TX_DATA valid
//  TX_READY       in   1        host accepts byte; handshake = TX_VALID & TX_READY
//  INPUTS_STATE   out  IN_W     registered input vector to DUT
//  OUTPUTS_STATE  in   OUT_W    output vector from DUT
//  AUTO_EN        out  1        auto-report mode active
//  CMD_ERR        out  1        one-cycle pulse on unknown command byte
// BEHAVIOUR
//  - Reset (RST_N=0 at CLK edge): INPUTS_STATE=0, TX_VALID=0, TX_DATA=0, RX_READY=0 during reset then 1,
//    AUTO_EN=0, CMD_ERR=0, last-reported snapshot=0, FSM=IDLE. Reset mid-frame aborts; no partial input update.
//  - Commands (first byte in IDLE): 0x01 WR_IN, 0x02 RD_OUT, 0x03 AUTO_ON, 0x04 AUTO_OFF; other -> CMD_ERR pulse, stay IDLE.
//  - FSM: IDLE -> RX_PAY (0x01) -> IDLE; IDLE -> TX_HDR -> TX_PAY -> IDLE (0x02 or auto trigger).
//  - WR_IN: next IN_BYTES bytes LSB-first into shadow reg; INPUTS_STATE updates atomically on the cycle after
//    the last payload handshake; bits above IN_W in last byte ignored. No response frame.
//  - Response frame: header 0xA5 then OUT_BYTES bytes LSB-first; pad bits above OUT_W are 0.
//  - Snapshot: OUTPUTS_STATE captured on the cycle FSM enters TX_HDR; frame content stable for whole frame;
//    last-reported snapshot := captured value (both RD_OUT and auto frames).
//  - TX_DATA/TX_VALID held stable while TX_VALID & !TX_READY; TX_VALID first asserted the cycle after TX_HDR entry.
//    Back-to-back: with TX_READY=1 constantly, frame occupies 1+OUT_BYTES consecutive cycles.
//  - RX_READY=1 only in IDLE and RX_PAY; 0 in TX_HDR/TX_PAY (host bytes backpressured, never dropped).
//  - AUTO_ON/AUTO_OFF set/clear AUTO_EN the cycle after the command handshake.
//  - Auto trigger: AUTO_EN & IDLE & (OUTPUTS_STATE != last-reported) & no RX handshake that cycle -> enter TX_HDR.
//  - Simultaneous RX handshake and auto trigger in IDLE: command wins; trigger re-evaluated on return to IDLE.
//  - Output glitches that revert before the trigger is evaluated produce no frame (level compare, no history).
//  - Byte counter width $clog2(max(IN_BYTES,OUT_BYTES)+1); wraps to 0 at frame end.
// STRUCTURE
//  - Package emu_io_pkg: command codes (CMD_WR_IN, CMD_RD_OUT, CMD_AUTO_ON, CMD_AUTO_OFF), RESP_HDR=8'hA5,
//    function nbytes(w)=ceil(w/8), FSM state enum.
//  - Sub-module emu_tx_serializer: loads {pad,snapshot}, emits header + bytes with valid/ready hold.
//  - Top holds command decode FSM, RX shadow/assembly, AUTO_EN, change compare.
// TESTING (IN_W=14, OUT_W=52 -> IN_BYTES=2, OUT_BYTES=7)
//  1 Reset: hold RST_N=0 2 cycles -> INPUTS_STATE=0, TX_VALID=0, AUTO_EN=0; release -> RX_READY=1.
//  2 WR_IN: send 01,34,E2 -> INPUTS_STATE=14'h2234 one cycle after last byte; unchanged before it.
//  3 RD_OUT, OUTPUTS_STATE=52'h0F_EDCB_A987_6543, TX_READY=1 -> A5,43,65,87,A9,CB,ED,0F over 8 cycles.
//  4 Backpressure: RD_OUT with TX_READY toggling 1/0 -> each byte held while stalled, same 8-byte sequence;
//    OUTPUTS_STATE changed mid-frame does not alter frame; RX_READY=0 throughout.
//  5 Auto: send 03, change OUTPUTS_STATE 0->52'h1 -> one frame A5,01,00x6; no further frame while stable;
//    send 04 then change -> no frame.
//  6 Errors/reset: send 7F -> CMD_ERR one cycle, no TX; send 01,34 then RST_N=0 -> INPUTS_STATE=0, FSM IDLE,
//    next 02 answered normally.

Source files
------------

// File: rtl/emu_io_bridge_pkg.sv
// Shared definitions for the emulator I/O bridge: command codes, response header,
// byte-count helper and the bridge FSM state type.
// Latency/backpressure: n/a (declarations only).
package emu_io_pkg;

    localparam logic [7:0] CMD_WR_IN    = 8'h01;
    localparam logic [7:0] CMD_RD_OUT   = 8'h02;
    localparam logic [7:0] CMD_AUTO_ON  = 8'h03;
    localparam logic [7:0] CMD_AUTO_OFF = 8'h04;
    localparam logic [7:0] RESP_HDR     = 8'hA5;

    // Number of bytes needed to carry a w-bit vector.
    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX_PAY = 2'd1,
        ST_TX_HDR = 2'd2,
        ST_TX_PAY = 2'd3
    } state_t;

endpackage

// File: rtl/emu_io_bridge_if.sv
// Host-side byte channels of the bridge: rx (host -> bridge) and tx (bridge -> host).
// Latency: n/a (wiring only).
// Backpressure: both channels are valid/ready; a byte moves when valid & ready.
// Ports: rx_data/rx_valid/rx_ready, tx_data/tx_valid/tx_ready.
interface emu_io_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Host / link side.
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    // Bridge side.
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/emu_io_bridge_tx_serializer.sv
// Emits one response frame: header byte then NB payload bytes LSB-first.
// Latency: first byte (header) valid the cycle after load_i.
// Backpressure: tx_data/tx_valid held while tx_ready is low; the frame is captured at load.
// Ports: clk_i, rst_n_i (sync, active-low), load_i + load_dat_i, tx_ready_i,
//        tx_data_o/tx_valid_o, hdr_done_o (header accepted), frame_done_o (last byte accepted).
module emu_tx_serializer
    import emu_io_pkg::*;
#(
    parameter int NB    = 7,
    parameter int CNT_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic [NB*8-1:0] load_dat_i,
    input  logic            tx_ready_i,
    output logic [7:0]      tx_data_o,
    output logic            tx_valid_o,
    output logic            hdr_done_o,
    output logic            frame_done_o
);

    logic [NB*8-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [7:0]       dat_q, dat_d;
    logic             hs;

    assign hs = vld_q & tx_ready_i;

    // cnt_q = index of the byte currently presented: 0 is the header, NB is the last payload byte.
    always_comb begin
        frame_d = frame_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        if (load_i) begin
            vld_d   = 1'b1;
            dat_d   = RESP_HDR;
            frame_d = load_dat_i;
            cnt_d   = '0;
        end else if (hs) begin
            if (cnt_q == CNT_W'(NB)) begin
                vld_d = 1'b0;
                dat_d = 8'h00;
                cnt_d = '0;
            end else begin
                dat_d   = frame_q[7:0];
                frame_d = frame_q >> 8;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

    assign tx_data_o    = dat_q;
    assign tx_valid_o   = vld_q;
    assign hdr_done_o   = hs && (cnt_q == '0);
    assign frame_done_o = hs && (cnt_q == CNT_W'(NB));

endmodule

// File: rtl/emu_io_bridge.sv
// Byte-stream bridge: host writes the DUT input vector and reads output snapshots; optional auto-report.
// Latency: input vector updates the cycle after the last payload byte; response header valid the cycle after the trigger.
// Backpressure: rx_ready low while a response frame is in flight; tx held stable while tx_ready is low.
// Ports: clk_i, rst_n_i (sync, active-low), bus (rx/tx byte channels), inputs_state_o (to DUT),
//        outputs_state_i (from DUT), auto_en_o (auto-report active), cmd_err_o (unknown command pulse).
module emu_io_bridge
    import emu_io_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 52
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    emu_io_bridge_if.slave   bus,
    output logic [IN_W-1:0]  inputs_state_o,
    input  logic [OUT_W-1:0] outputs_state_i,
    output logic             auto_en_o,
    output logic             cmd_err_o
);

    localparam int IN_BYTES  = nbytes(IN_W);
    localparam int OUT_BYTES = nbytes(OUT_W);
    localparam int CNT_W     = $clog2(imax(IN_BYTES, OUT_BYTES) + 1);
    localparam int OB_W      = OUT_BYTES * 8;
    // Shadow holds every payload byte except the last, which is taken straight from the bus.
    localparam int SH_W      = (IN_BYTES > 1) ? (IN_BYTES - 1) * 8 : 8;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic [IN_W-1:0]   inputs_q, inputs_d;
    logic              auto_en_q, auto_en_d;
    logic              cmd_err_q, cmd_err_d;
    logic [OUT_W-1:0]  last_rep_q, last_rep_d;

    logic rx_hs;
    logic trigger;
    logic last_pay;
    logic ser_load;
    logic hdr_done;
    logic frame_done;

    assign rx_hs    = bus.rx_valid & bus.rx_ready;
    assign last_pay = (rx_cnt_q == CNT_W'(IN_BYTES - 1));
    // A host command accepted in the same cycle takes priority; the compare is re-evaluated in IDLE later.
    assign trigger  = auto_en_q && (outputs_state_i != last_rep_q) && !rx_hs;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_hs) begin
                    if (bus.rx_data == CMD_WR_IN) begin
                        state_d = ST_RX_PAY;
                    end else if (bus.rx_data == CMD_RD_OUT) begin
                        state_d = ST_TX_HDR;
                    end
                end else if (trigger) begin
                    state_d = ST_TX_HDR;
                end
            end
            ST_RX_PAY: if (rx_hs && last_pay) state_d = ST_IDLE;
            ST_TX_HDR: if (hdr_done)          state_d = ST_TX_PAY;
            ST_TX_PAY: if (frame_done)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next-state.
    always_comb begin
        bus.rx_ready = rst_n_i && ((state_q == ST_IDLE) || (state_q == ST_RX_PAY));
        ser_load     = (state_q == ST_IDLE) &&
                       ((rx_hs && (bus.rx_data == CMD_RD_OUT)) || trigger);
        rx_cnt_d     = rx_cnt_q;
        shadow_d     = shadow_q;
        inputs_d     = inputs_q;
        auto_en_d    = auto_en_q;
        cmd_err_d    = 1'b0;
        last_rep_d   = last_rep_q;

        if ((state_q == ST_IDLE) && rx_hs) begin
            case (bus.rx_data)
                CMD_WR_IN:    rx_cnt_d  = '0;
                CMD_RD_OUT:   ;
                CMD_AUTO_ON:  auto_en_d = 1'b1;
                CMD_AUTO_OFF: auto_en_d = 1'b0;
                default:      cmd_err_d = 1'b1;
            endcase
        end

        if ((state_q == ST_RX_PAY) && rx_hs) begin
            if (last_pay) begin
                // Whole vector commits at once; bits above IN_W in the last byte fall off here.
                if (IN_BYTES == 1) begin
                    inputs_d = IN_W'(bus.rx_data);
                end else begin
                    inputs_d = IN_W'({bus.rx_data, shadow_q});
                end
                rx_cnt_d = '0;
            end else begin
                shadow_d = (shadow_q >> 8) | (SH_W'(bus.rx_data) << (SH_W - 8));
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
        end

        // The value framed is the value remembered, so auto-report compares against what was sent.
        if (ser_load) begin
            last_rep_d = outputs_state_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_cnt_q   <= '0;
            shadow_q   <= '0;
            inputs_q   <= '0;
            auto_en_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            last_rep_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            shadow_q   <= shadow_d;
            inputs_q   <= inputs_d;
            auto_en_q  <= auto_en_d;
            cmd_err_q  <= cmd_err_d;
            last_rep_q <= last_rep_d;
        end
    end

    emu_tx_serializer #(
        .NB    (OUT_BYTES),
        .CNT_W (CNT_W)
    ) u_tx (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (ser_load),
        .load_dat_i   (OB_W'(outputs_state_i)),
        .tx_ready_i   (bus.tx_ready),
        .tx_data_o    (bus.tx_data),
        .tx_valid_o   (bus.tx_valid),
        .hdr_done_o   (hdr_done),
        .frame_done_o (frame_done)
    );

    assign inputs_state_o = inputs_q;
    assign auto_en_o      = auto_en_q;
    assign cmd_err_o      = cmd_err_q;

endmodule
